// File: rtl/clock_timekeeper_pkg.sv
// Shared constants for the clock_timekeeper block.
// Holds the field-select encodings, BCD field limits, reset time-of-day and
// the BCD legality helper used by the field counters.
package clock_timekeeper_pkg;

  typedef enum logic [1:0] {
    SEL_SS = 2'd0,
    SEL_MM = 2'd1,
    SEL_HH = 2'd2,
    SEL_PM = 2'd3
  } field_sel_e;

  // BCD limits
  localparam logic [7:0] BCD_ZERO    = 8'h00;
  localparam logic [7:0] BCD_MAX_60  = 8'h59;
  localparam logic [7:0] BCD_HR_MAX  = 8'h12;
  localparam logic [7:0] BCD_HR_MIN  = 8'h01;
  // Hour value whose increment flips AM/PM (11 -> 12)
  localparam logic [7:0] BCD_HR_PM_EDGE = 8'h11;

  // Reset time-of-day: 12:00:00 AM
  localparam logic [7:0] RST_SS = 8'h00;
  localparam logic [7:0] RST_MM = 8'h00;
  localparam logic [7:0] RST_HH = 8'h12;
  localparam logic       RST_PM = 1'b0;

  // True when v is packed BCD (both digits 0-9) and lies within [lo, hi].
  function automatic logic bcd_in_range(input logic [7:0] v,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/clock_timekeeper_bcd_field_counter.sv
// bcd_field_counter: one 8-bit packed-BCD time field.
// Ports:
//   i_clk, i_reset_n  clock and synchronous active-low reset
//   i_inc             advance by one (wraps MAX_VAL -> MIN_VAL)
//   i_load            load i_load_val this edge, only if it is legal
//   i_load_val        candidate load value
//   o_val             registered field value
//   o_carry           combinational: this edge wraps the field (inc at max)
//   o_legal           combinational: i_load_val is a legal value for the field
module bcd_field_counter
  import clock_timekeeper_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = 8'h59,
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_inc,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_val,
  output logic       o_carry,
  output logic       o_legal
);

  logic [7:0] val_q;
  logic [7:0] val_d;

  assign o_legal = bcd_in_range(i_load_val, MIN_VAL, MAX_VAL);
  assign o_carry = i_inc && (val_q == MAX_VAL);
  assign o_val   = val_q;

  // Next-state: legal load beats increment; increment wraps at max, else BCD +1.
  always_comb begin
    val_d = val_q;
    if (i_load && o_legal) begin
      val_d = i_load_val;
    end else if (i_inc) begin
      if (val_q == MAX_VAL) begin
        val_d = MIN_VAL;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end else begin
      val_d = val_q;
    end
  end

  // Field register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: 12-hour BCD time-of-day counter with editor write port.
// Ports:
//   i_clk, i_reset_n  clock and synchronous active-low reset (-> 12:00:00 AM)
//   i_tick            1 Hz one-cycle strobe; ignored while i_wr is high
//   i_wr              edit mode level; freezes counting, enables field loads
//   i_sel, i_val      field select (ss/mm/hh/pm) and packed-BCD load value
//   o_ss, o_mm, o_hh  registered BCD time fields
//   o_pm              registered AM(0)/PM(1) flag
//   o_reject          one-cycle pulse after an out-of-range write attempt
//   o_min_pulse       one-cycle pulse after each counted 59->00 seconds wrap
module clock_timekeeper
  import clock_timekeeper_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick,
  input  logic       i_wr,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_val,
  output logic [7:0] o_ss,
  output logic [7:0] o_mm,
  output logic [7:0] o_hh,
  output logic       o_pm,
  output logic       o_reject,
  output logic       o_min_pulse
);

  field_sel_e sel_s;
  logic       ss_inc_s, mm_inc_s, hh_inc_s;
  logic       ss_load_s, mm_load_s, hh_load_s, pm_load_s;
  logic       ss_legal_s, mm_legal_s, hh_legal_s;
  logic       ss_carry_s;
  logic       pm_q, pm_d;
  logic       reject_q, reject_d;
  logic       min_pulse_q, min_pulse_d;

  assign sel_s = field_sel_e'(i_sel);

  // A tick that arrives in edit mode is dropped, not deferred.
  assign ss_inc_s = i_tick && !i_wr;
  assign mm_inc_s = ss_carry_s;

  // Select decode for field loads.
  always_comb begin
    ss_load_s = 1'b0;
    mm_load_s = 1'b0;
    hh_load_s = 1'b0;
    pm_load_s = 1'b0;
    if (i_wr) begin
      case (sel_s)
        SEL_SS:  ss_load_s = 1'b1;
        SEL_MM:  mm_load_s = 1'b1;
        SEL_HH:  hh_load_s = 1'b1;
        SEL_PM:  pm_load_s = 1'b1;
        default: ss_load_s = 1'b0;
      endcase
    end else begin
      ss_load_s = 1'b0;
    end
  end

  bcd_field_counter #(
    .MAX_VAL(BCD_MAX_60), .MIN_VAL(BCD_ZERO), .RST_VAL(RST_SS)
  ) u_ss (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(ss_inc_s), .i_load(ss_load_s),
    .i_load_val(i_val), .o_val(o_ss), .o_carry(ss_carry_s), .o_legal(ss_legal_s)
  );

  bcd_field_counter #(
    .MAX_VAL(BCD_MAX_60), .MIN_VAL(BCD_ZERO), .RST_VAL(RST_MM)
  ) u_mm (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(mm_inc_s), .i_load(mm_load_s),
    .i_load_val(i_val), .o_val(o_mm), .o_carry(hh_inc_s), .o_legal(mm_legal_s)
  );

  // Hours wrap 12 -> 01; its own wrap drives nothing further.
  bcd_field_counter #(
    .MAX_VAL(BCD_HR_MAX), .MIN_VAL(BCD_HR_MIN), .RST_VAL(RST_HH)
  ) u_hh (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_inc(hh_inc_s), .i_load(hh_load_s),
    .i_load_val(i_val), .o_val(o_hh), .o_carry(), .o_legal(hh_legal_s)
  );

  // AM/PM flips on 11 -> 12, not on the 12 -> 01 wrap.
  always_comb begin
    pm_d = pm_q;
    if (pm_load_s) begin
      pm_d = i_val[0];
    end else if (hh_inc_s && (o_hh == BCD_HR_PM_EDGE)) begin
      pm_d = ~pm_q;
    end else begin
      pm_d = pm_q;
    end
  end

  // Reject when the selected field would not accept i_val.
  always_comb begin
    reject_d = 1'b0;
    if (i_wr) begin
      case (sel_s)
        SEL_SS:  reject_d = !ss_legal_s;
        SEL_MM:  reject_d = !mm_legal_s;
        SEL_HH:  reject_d = !hh_legal_s;
        SEL_PM:  reject_d = 1'b0;
        default: reject_d = 1'b0;
      endcase
    end else begin
      reject_d = 1'b0;
    end
  end

  // Seconds carry only happens while counting, so writes never pulse this.
  assign min_pulse_d = ss_carry_s;

  // AM/PM flag and status pulse registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pm_q        <= RST_PM;
      reject_q    <= 1'b0;
      min_pulse_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      reject_q    <= reject_d;
      min_pulse_q <= min_pulse_d;
    end
  end

  assign o_pm        = pm_q;
  assign o_reject    = reject_q;
  assign o_min_pulse = min_pulse_q;

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Time-of-day register bank and 12-hour BCD counter that sits on the write side of the clock editor. It advances seconds, minutes, hours and AM/PM on a one-cycle seconds strobe. It accepts field writes (select plus value) from the editor while write mode is held. Its outputs drive both the display path and the editor's current-value inputs.

## Interface
Parameters:
- none; all field ranges are fixed constants in the shared package.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_tick  in  1  one-cycle seconds strobe (1 Hz pulse from prescaler).
- i_wr  in  1  edit/write mode level from the editor.
- i_sel  in  2  field select: 0 = seconds, 1 = minutes, 2 = hours, 3 = AM/PM.
- i_val  in  8  packed BCD value for the selected field (bit 0 only for AM/PM).
- o_ss  out  8  seconds, BCD 0x00–0x59.
- o_mm  out  8  minutes, BCD 0x00–0x59.
- o_hh  out  8  hours, BCD 0x01–0x12.
- o_pm  out  1  0 = AM, 1 = PM.
- o_reject  out  1  one-cycle pulse: write value out of range, not loaded.
- o_min_pulse  out  1  one-cycle pulse on each 59→00 seconds rollover.

## Operation
- Reset (i_reset_n = 0 at a clock edge):
  - o_hh=0x12, o_mm=0x00, o_ss=0x00, o_pm=0.
  - o_reject=0, o_min_pulse=0.
  - Reset overrides tick and write in the same cycle.
- Run mode (i_wr = 0):
  - Each i_tick increments ss.
  - ss 0x59→0x00 increments mm; mm 0x59→0x00 increments hh. All carries resolve on the same edge.
  - hh 0x11→0x12 toggles pm.
  - hh 0x12→0x01 does not toggle pm.
  - Each BCD digit carries at 9→0.
- Write mode (i_wr = 1):
  - Counting is frozen; i_tick is ignored and dropped, not queued.
  - Every cycle, the field chosen by i_sel loads i_val if the value is legal. Non-selected fields hold.
  - Legal values:
    - ss, mm: both nibbles ≤ 9 and value ≤ 0x59.
    - hh: 0x01–0x09 or 0x10–0x12.
    - pm: any value; loads i_val[0], bits 7:1 ignored.
  - Illegal value: the field holds and o_reject pulses for that cycle. o_reject stays high each cycle the illegal value persists.
- Leaving write mode: counting resumes on the next i_tick. Loaded seconds are not reset, and there is no prescaler interaction.
- o_min_pulse fires only on counting rollover, never on a write.

## Timing
- All outputs are registered.
- A write is visible on the outputs the cycle after the edge where i_wr = 1.
- A tick is visible the cycle after the i_tick edge.
- Tick and write in the same cycle: the write wins and the tick is lost.
- o_reject and o_min_pulse are asserted for exactly the cycle after the causing edge.
- Reset mid-write or mid-carry: all state returns to 12:00:00 AM on that edge, with no partial carry.
- i_sel may change every cycle while i_wr = 1. Each cycle's load uses that cycle's i_sel.

## Structure
- Shared package contents:
  - field-select encodings (SEL_SS, SEL_MM, SEL_HH, SEL_PM);
  - BCD limit constants (0x59, 0x12, 0x01);
  - reset time constants.
- Sub-module bcd_field_counter:
  - 8-bit BCD register with inc, load, load-value and max/min parameters;
  - outputs carry-out and a legal-value flag.
- The top instantiates three bcd_field_counter instances (ss, mm, hh), the pm flop and the select decode.
- The hh instance wraps max→min (12→01), not →00.

## Test plan
- Reset: assert i_reset_n = 0 for 1 cycle with i_tick = 1 → outputs 0x12:0x00:0x00, pm = 0; no pulses.
- Full-day rollover: preset 11:59:58 AM, apply 2 ticks → 11:59:59 AM, then 12:00:00 with pm = 1 and o_min_pulse once. Preset 12:59:59 PM, apply 1 tick → 01:00:00, pm stays 1.
- Write fields: i_wr = 1, then in turn sel = 1/val = 0x45, sel = 2/val = 0x07, sel = 3/val = 0x01 → 07:45:ss PM, each visible 1 cycle after its write, ss unchanged.
- Illegal writes: sel = 0/val = 0x60, sel = 1/val = 0x3A, sel = 2/val = 0x00, sel = 2/val = 0x13 → fields unchanged, o_reject high exactly those cycles.
- Tick during write: i_wr = 1 and i_tick = 1 on the same edge, writing sel = 0/val = 0x30 → ss = 0x30, not 0x31. After i_wr drops, next tick → 0x31.
- Reset mid-edit: i_wr = 1 loading hh = 0x09, then i_reset_n = 0 on the next edge → 12:00:00 AM, no o_reject.
